// File: rtl/pwm_deadband_gen_pkg.sv
// pwm_deadband_gen_pkg: shared state encoding and defaults
// for the dead-band generator slice.
package pwm_deadband_gen_pkg;

    localparam int DT_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_LOW  = 3'd1,
        S_DR   = 3'd2,
        S_HIGH = 3'd3,
        S_DF   = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_deadband_gen_if.sv
// pwm_deadband_gen_if: control/drive bundle of the dead-band stage.
// Fault signals exist only when PWM_DT_FAULT_EN is defined.
interface pwm_deadband_gen_if
    import pwm_deadband_gen_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
);
    logic                enable;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dt_rise;
    logic [DT_WIDTH-1:0] dt_fall;
    logic                pwm_h;
    logic                pwm_l;
    logic                dt_busy;

`ifdef PWM_DT_FAULT_EN
    logic fault_in;
    logic fault_clr;
    logic fault_flag;

    modport master (
        output enable, pwm_in, dt_rise, dt_fall,
        output fault_in, fault_clr,
        input  pwm_h, pwm_l, dt_busy, fault_flag
    );

    modport slave (
        input  enable, pwm_in, dt_rise, dt_fall,
        input  fault_in, fault_clr,
        output pwm_h, pwm_l, dt_busy, fault_flag
    );
`else
    modport master (
        output enable, pwm_in, dt_rise, dt_fall,
        input  pwm_h, pwm_l, dt_busy
    );

    modport slave (
        input  enable, pwm_in, dt_rise, dt_fall,
        output pwm_h, pwm_l, dt_busy
    );
`endif

endinterface

// File: rtl/pwm_deadband_gen_dt_counter.sv
// pwm_dt_counter: loadable dead-time down-counter shared by
// both dead states; saturates at 1 instead of wrapping.
module pwm_dt_counter #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DT_WIDTH-1:0] value,
    input  logic                dec,
    output logic                cnt_is_one
);
    localparam logic [DT_WIDTH-1:0] ONE = DT_WIDTH'(1);

    logic [DT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt > ONE)) begin
            cnt <= cnt - ONE;
        end
    end

    assign cnt_is_one = (cnt == ONE);

endmodule

// File: rtl/pwm_deadband_gen.sv
// pwm_deadband_gen: complementary high/low drive with dead time.
// Optional fault latch when PWM_DT_FAULT_EN is defined.
module pwm_deadband_gen
    import pwm_deadband_gen_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pwm_deadband_gen_if.slave bus
);
    state_t              state;
    state_t              nxt;
    state_t              rise_st;
    state_t              fall_st;
    logic                in_q;
    logic                h_q;
    logic                l_q;
    logic                busy_q;
    logic                flt;
    logic                load;
    logic                dec;
    logic                cnt_is_one;
    logic [DT_WIDTH-1:0] ld_val;

`ifdef PWM_DT_FAULT_EN
    logic flag_q;

    // fault_in wins over fault_clr on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else if (bus.fault_in) begin
            flag_q <= 1'b1;
        end else if (bus.fault_clr) begin
            flag_q <= 1'b0;
        end
    end

    assign flt            = bus.fault_in | flag_q;
    assign bus.fault_flag = flag_q;
`else
    assign flt = 1'b0;
`endif

    // zero dead time skips the dead state entirely
    assign rise_st = (bus.dt_rise == '0) ? S_HIGH : S_DR;
    assign fall_st = (bus.dt_fall == '0) ? S_LOW : S_DF;

    always_comb begin
        nxt    = state;
        load   = 1'b0;
        dec    = 1'b0;
        ld_val = bus.dt_fall;
        if (!bus.enable || flt) begin
            nxt = S_OFF;
        end else begin
            unique case (state)
                S_OFF: begin
                    load = 1'b1;
                    if (in_q) begin
                        nxt    = rise_st;
                        ld_val = bus.dt_rise;
                    end else begin
                        nxt = fall_st;
                    end
                end
                S_LOW: begin
                    if (in_q) begin
                        nxt    = rise_st;
                        load   = 1'b1;
                        ld_val = bus.dt_rise;
                    end
                end
                S_HIGH: begin
                    if (!in_q) begin
                        nxt  = fall_st;
                        load = 1'b1;
                    end
                end
                S_DR: begin
                    if (!in_q) begin
                        nxt  = fall_st;
                        load = 1'b1;
                    end else if (cnt_is_one) begin
                        nxt = S_HIGH;
                    end else begin
                        dec = 1'b1;
                    end
                end
                S_DF: begin
                    if (in_q) begin
                        nxt    = rise_st;
                        load   = 1'b1;
                        ld_val = bus.dt_rise;
                    end else if (cnt_is_one) begin
                        nxt = S_LOW;
                    end else begin
                        dec = 1'b1;
                    end
                end
                default: nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_OFF;
            in_q   <= 1'b0;
            h_q    <= 1'b0;
            l_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= nxt;
            in_q   <= bus.pwm_in;
            h_q    <= (nxt == S_HIGH);
            l_q    <= (nxt == S_LOW);
            busy_q <= (nxt == S_DR) || (nxt == S_DF);
        end
    end

    pwm_dt_counter #(
        .DT_WIDTH (DT_WIDTH)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (ld_val),
        .dec        (dec),
        .cnt_is_one (cnt_is_one)
    );

    assign bus.pwm_h   = h_q;
    assign bus.pwm_l   = l_q;
    assign bus.dt_busy = busy_q;

endmodule

// File: tb/tb_pwm_deadband_gen.sv
// tb_pwm_deadband_gen: vector table, directed corner cases and
// randomized run against a time-since-transition reference model.
module tb_pwm_deadband_gen;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pwm_deadband_gen_if #(.DT_WIDTH(8)) bus ();

    pwm_deadband_gen #(
        .DT_WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t",
                     nm, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: after entering a level (or leaving off), outputs
    // stay both-low for 'dead' edges, then follow the level.
    int   m_t;
    int   m_since;
    int   m_dead;
    bit   m_run;
    bit   m_lvl;
    bit   m_inq;
    bit   m_flag;
    bit   m_off;
    logic exp_h;
    logic exp_l;
    logic exp_b;

    initial begin
        m_t   = 0;
        m_run = 0;
        m_inq = 0;
        m_flag = 0;
        exp_h = 0;
        exp_l = 0;
        exp_b = 0;
    end

    always @(posedge clk) begin
        m_t++;
        if (reset) begin
            m_run  = 0;
            m_inq  = 0;
            m_flag = 0;
        end else begin
            m_off = !bus.enable;
`ifdef PWM_DT_FAULT_EN
            m_off = m_off | bus.fault_in | m_flag;
            if (bus.fault_in) m_flag = 1;
            else if (bus.fault_clr) m_flag = 0;
`endif
            if (m_off) begin
                m_run = 0;
            end else if (!m_run || m_inq != m_lvl) begin
                m_run   = 1;
                m_lvl   = m_inq;
                m_dead  = m_inq ? int'(bus.dt_rise)
                                : int'(bus.dt_fall);
                m_since = m_t;
            end
            m_inq = bus.pwm_in;
        end
        if (!m_run) begin
            {exp_h, exp_l, exp_b} = 3'b000;
        end else if (m_t - m_since < m_dead) begin
            {exp_h, exp_l, exp_b} = 3'b001;
        end else begin
            {exp_h, exp_l, exp_b} = {m_lvl, !m_lvl, 1'b0};
        end
    end

    always @(negedge clk) begin
        if (m_t > 0) begin
            chk("model_hlb",
                int'({bus.pwm_h, bus.pwm_l, bus.dt_busy}),
                int'({exp_h, exp_l, exp_b}));
            chk("overlap", int'(bus.pwm_h & bus.pwm_l), 0);
`ifdef PWM_DT_FAULT_EN
            chk("model_flag", int'(bus.fault_flag), int'(m_flag));
`endif
        end
    end

    typedef struct {
        bit         rst;
        bit         en;
        bit         pin;
        logic [7:0] dtr;
        logic [7:0] dtf;
        bit         eh;
        bit         el;
        bit         eb;
    } vec_t;

    vec_t tbl [16];
    int   run;
    int   cnt;
    int   runleft;
    int   en_hold;
    bit   prev_h;
    bit   prev_l;
    bit   prev_p;
    bit   p;
    bit   found;

    initial begin
        checks   = 0;
        failures = 0;
        tbl[0]  = '{1, 1, 1, 8'd2, 8'd1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 8'd2, 8'd1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 8'd2, 8'd1, 0, 0, 1};
        tbl[3]  = '{0, 1, 1, 8'd2, 8'd1, 0, 0, 1};
        tbl[4]  = '{0, 1, 1, 8'd2, 8'd1, 0, 0, 1};
        tbl[5]  = '{0, 1, 0, 8'd2, 8'd1, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 8'd2, 8'd1, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 8'd2, 8'd1, 0, 1, 0};
        tbl[8]  = '{0, 1, 1, 8'd2, 8'd1, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 8'd2, 8'd1, 0, 0, 1};
        tbl[10] = '{0, 1, 0, 8'd2, 8'd1, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 8'd2, 8'd1, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 8'd2, 8'd1, 0, 0, 0};
        tbl[13] = '{0, 1, 1, 8'd0, 8'd0, 0, 1, 0};
        tbl[14] = '{0, 1, 1, 8'd0, 8'd0, 1, 0, 0};
        tbl[15] = '{1, 1, 1, 8'd0, 8'd0, 0, 0, 0};

`ifdef PWM_DT_FAULT_EN
        bus.fault_in  = 0;
        bus.fault_clr = 0;
`endif
        for (int i = 0; i < 16; i++) begin
            reset       = tbl[i].rst;
            bus.enable  = tbl[i].en;
            bus.pwm_in  = tbl[i].pin;
            bus.dt_rise = tbl[i].dtr;
            bus.dt_fall = tbl[i].dtf;
            step();
            chk($sformatf("vec%0d", i),
                int'({bus.pwm_h, bus.pwm_l, bus.dt_busy}),
                int'({tbl[i].eh, tbl[i].el, tbl[i].eb}));
        end

        // 50% square, period 32
        reset = 0;
        bus.dt_rise = 8'd4;
        bus.dt_fall = 8'd6;
        run = 0;
        prev_h = 0;
        prev_l = 0;
        for (int i = 0; i < 160; i++) begin
            bus.pwm_in = ((i % 32) < 16);
            step();
            if (!bus.pwm_h && !bus.pwm_l) begin
                run++;
            end else begin
                if (i >= 32 && bus.pwm_h && !prev_h)
                    chk("sq_rise_dead", run, 4);
                if (i >= 32 && bus.pwm_l && !prev_l)
                    chk("sq_fall_dead", run, 6);
                run = 0;
            end
            prev_h = bus.pwm_h;
            prev_l = bus.pwm_l;
        end

        // short pulse swallowed
        bus.dt_rise = 8'd5;
        bus.dt_fall = 8'd2;
        bus.pwm_in  = 0;
        repeat (12) step();
        chk("pulse_pre_low", int'(bus.pwm_l), 1);
        run = 0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            bus.pwm_in = (i < 2);
            step();
            run += int'(bus.pwm_h);
            cnt += int'(bus.dt_busy);
        end
        chk("pulse_no_h", run, 0);
        chk("pulse_busy", cnt, 4);
        chk("pulse_l_back", int'(bus.pwm_l), 1);

        // zero dead time: h follows in_q one edge later
        bus.dt_rise = 8'd0;
        bus.dt_fall = 8'd0;
        bus.pwm_in  = 0;
        repeat (8) step();
        prev_p = 0;
        for (int i = 0; i < 24; i++) begin
            p = 1'($urandom_range(0, 1));
            bus.pwm_in = p;
            step();
            chk("dt0_h", int'(bus.pwm_h), int'(prev_p));
            chk("dt0_l", int'(bus.pwm_l), int'(!prev_p));
            chk("dt0_busy", int'(bus.dt_busy), 0);
            prev_p = p;
        end

        // enable drop mid-high, then re-enable
        bus.dt_rise = 8'd3;
        bus.dt_fall = 8'd2;
        bus.pwm_in  = 1;
        repeat (12) step();
        chk("en_pre_high", int'(bus.pwm_h), 1);
        bus.enable = 0;
        step();
        chk("en_off", int'({bus.pwm_h, bus.pwm_l}), 0);
        bus.enable = 1;
        cnt = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.pwm_h) found = 1;
            else cnt += int'(bus.dt_busy);
        end
        chk("en_h_back", int'(found), 1);
        chk("en_dead", cnt, 3);

`ifdef PWM_DT_FAULT_EN
        bus.pwm_in = 1;
        repeat (6) step();
        chk("flt_pre_high", int'(bus.pwm_h), 1);
        bus.fault_in = 1;
        step();
        bus.fault_in = 0;
        chk("flt_off", int'({bus.pwm_h, bus.pwm_l}), 0);
        chk("flt_flag", int'(bus.fault_flag), 1);
        repeat (4) step();
        chk("flt_hold", int'({bus.pwm_h, bus.pwm_l}), 0);
        chk("flt_flag_hold", int'(bus.fault_flag), 1);
        bus.fault_clr = 1;
        step();
        bus.fault_clr = 0;
        chk("flt_clr", int'(bus.fault_flag), 0);
        cnt = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.pwm_h) found = 1;
            else cnt += int'(bus.dt_busy);
        end
        chk("flt_h_back", int'(found), 1);
        chk("flt_dead", cnt, 3);
`endif

        // randomized run
        runleft = 0;
        en_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (runleft == 0) begin
                bus.pwm_in = ~bus.pwm_in;
                runleft = $urandom_range(1, 12);
            end
            runleft--;
            if ($urandom_range(0, 19) == 0)
                bus.dt_rise = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0)
                bus.dt_fall = 8'($urandom_range(0, 7));
            if (en_hold > 0) begin
                en_hold--;
                bus.enable = 0;
            end else begin
                bus.enable = 1;
                if ($urandom_range(0, 149) == 0)
                    en_hold = $urandom_range(1, 4);
            end
            reset = ($urandom_range(0, 499) == 0);
`ifdef PWM_DT_FAULT_EN
            bus.fault_in  = ($urandom_range(0, 199) == 0);
            bus.fault_clr = ($urandom_range(0, 24) == 0);
`endif
            step();
        end

        reset = 0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
